// File: rtl/bit_serial_pkg.sv
// rtl/bit_serial_pkg.sv - shared state encoding and line levels for the bit-serial link.
// Used by both the transmitter and the matching shift-register receiver.
package bit_serial_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } bs_state_t;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_LVL = 1'b0;
    localparam logic STOP_LVL  = 1'b1;

endpackage

// File: rtl/bit_serial_baud_cnt.sv
// rtl/bit_serial_baud_cnt.sv - bit-period divider, counts 0..DIV-1 and flags the last cycle.
// next_last_o tells the FSM one cycle ahead that the coming cycle is the last of a bit.
module bit_serial_baud_cnt #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear_i,
    output logic last_tick_o,
    output logic next_last_o
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clear_i || (cnt_q == LAST_CNT)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last_tick_o = (cnt_q == LAST_CNT);
    assign next_last_o = (cnt_d == LAST_CNT);

endmodule

// File: rtl/bit_serial_tx.sv
// rtl/bit_serial_tx.sv - parallel-to-serial frame transmitter (start, data, optional parity, stop).
// Define BIT_SERIAL_TX_PARITY_EN to insert an even-parity bit between data and stop.
module bit_serial_tx
    import bit_serial_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DIV       = 4,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             tx,
    output logic             busy
);

    localparam int BCW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BCW-1:0] LAST_BIT = BCW'(WIDTH - 1);

    bs_state_t        state_q;
    logic [WIDTH-1:0] shreg_q;
    logic [BCW-1:0]   bit_cnt_q;
    logic             tx_q;
    logic             busy_q;
    logic             in_ready_q;
`ifdef BIT_SERIAL_TX_PARITY_EN
    logic             parity_q;
`endif

    logic             accept;
    logic             last_tick;
    logic             next_last;
    logic             shift_bit;
    logic [WIDTH-1:0] shreg_next;

    assign accept     = in_valid && in_ready_q;
    assign shift_bit  = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
    assign shreg_next = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);

    bit_serial_baud_cnt #(
        .DIV(DIV)
    ) u_baud (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear_i    (accept),
        .last_tick_o(last_tick),
        .next_last_o(next_last)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            tx_q       <= LINE_IDLE;
            busy_q     <= 1'b0;
            in_ready_q <= 1'b0;
`ifdef BIT_SERIAL_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    busy_q     <= 1'b0;
                    in_ready_q <= 1'b1;
                    if (accept) begin
                        state_q    <= START;
                        shreg_q    <= in_data;
                        tx_q       <= START_LVL;
                        busy_q     <= 1'b1;
                        in_ready_q <= 1'b0;
`ifdef BIT_SERIAL_TX_PARITY_EN
                        parity_q   <= ^in_data;
`endif
                    end
                end
                START: begin
                    if (last_tick) begin
                        state_q   <= DATA;
                        tx_q      <= shift_bit;
                        shreg_q   <= shreg_next;
                        bit_cnt_q <= '0;
                    end
                end
                DATA: begin
                    if (last_tick) begin
                        if (bit_cnt_q == LAST_BIT) begin
                            bit_cnt_q <= '0;
`ifdef BIT_SERIAL_TX_PARITY_EN
                            state_q   <= PARITY;
                            tx_q      <= parity_q;
`else
                            state_q    <= STOP;
                            tx_q       <= STOP_LVL;
                            in_ready_q <= next_last;
`endif
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                            tx_q      <= shift_bit;
                            shreg_q   <= shreg_next;
                        end
                    end
                end
`ifdef BIT_SERIAL_TX_PARITY_EN
                PARITY: begin
                    if (last_tick) begin
                        state_q    <= STOP;
                        tx_q       <= STOP_LVL;
                        in_ready_q <= next_last;
                    end
                end
`endif
                STOP: begin
                    // in_ready is raised only for the final STOP cycle so frames chain without a gap
                    if (last_tick) begin
                        if (accept) begin
                            state_q    <= START;
                            shreg_q    <= in_data;
                            tx_q       <= START_LVL;
                            in_ready_q <= 1'b0;
`ifdef BIT_SERIAL_TX_PARITY_EN
                            parity_q   <= ^in_data;
`endif
                        end else begin
                            state_q    <= IDLE;
                            tx_q       <= LINE_IDLE;
                            busy_q     <= 1'b0;
                            in_ready_q <= 1'b1;
                        end
                    end else begin
                        in_ready_q <= next_last;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    tx_q       <= LINE_IDLE;
                    busy_q     <= 1'b0;
                    in_ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready = in_ready_q;
    assign tx       = tx_q;
    assign busy     = busy_q;

endmodule
